write_back_stage: RTL and testbench

- Final core pipeline stage; the write side matching the operand-read stage.
- Accepts completed instruction bundles, buffers them, and commits results to the GPR file write port.
- System-register writes (MTS) go out over a req/ack handshake.
- Emits one retire pulse per committed instruction, in program order.

---
 rtl/write_back_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_write_back_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// -----------------------------------------------------------------------------
// write_back_stage
//
// Final pipeline stage of the core. It buffers completed instruction bundles in
// a small in-order FIFO and commits the oldest one per cycle:
//   - GPR results drive a single-cycle write strobe on the register-file port.
//   - System-register results (MTS) are sent over a req/ack handshake. The
//     request is held until acknowledged, and all younger entries wait behind it.
//   - Every committed instruction produces one retire pulse, in program order.
//
// Optional feature (macro WB_RETIRE_COUNT_EN):
//   Adds a 64-bit retire_count output. It counts retire pulses, resets to 0 and
//   wraps modulo 2^64.
//
// Ports:
//   clk, rst          core clock; asynchronous active-high reset
//   in_valid/in_ready result bundle handshake (in_ready = buffer not full)
//   in_addr           instruction word address
//   in_wen, in_is_sys destination write enable; destination is a sysreg
//   in_rd, in_sysreg  destination GPR index / sysreg id
//   in_data           result value
//   gpr_we/waddr/wdata   registered GPR write port
//   sys_req/id/data      registered sysreg write request, held until sys_ack
//   sys_ack              sysreg write accepted (single-cycle pulse)
//   retire_valid/addr    registered retire pulse and instruction address
//   retire_count         (WB_RETIRE_COUNT_EN only) retired-instruction counter
// -----------------------------------------------------------------------------
module write_back_stage #(
  parameter int ADDR_WIDTH      = 30,
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ID_WIDTH    = 5,
  parameter int SYSREG_ID_WIDTH = 10,
  parameter int DEPTH           = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic                       in_wen,
  input  logic                       in_is_sys,
  input  logic [REG_ID_WIDTH-1:0]    in_rd,
  input  logic [SYSREG_ID_WIDTH-1:0] in_sysreg,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       gpr_we,
  output logic [REG_ID_WIDTH-1:0]    gpr_waddr,
  output logic [DATA_WIDTH-1:0]      gpr_wdata,
  output logic                       sys_req,
  output logic [SYSREG_ID_WIDTH-1:0] sys_id,
  output logic [DATA_WIDTH-1:0]      sys_data,
  input  logic                       sys_ack,
  output logic                       retire_valid,
  output logic [ADDR_WIDTH-1:0]      retire_addr
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]                retire_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_SYS_WAIT = 1'b1
  } state_t;

  // Buffer storage (data only, not reset)
  logic [ADDR_WIDTH-1:0]      mem_addr_q   [DEPTH];
  logic                       mem_wen_q    [DEPTH];
  logic                       mem_is_sys_q [DEPTH];
  logic [REG_ID_WIDTH-1:0]    mem_rd_q     [DEPTH];
  logic [SYSREG_ID_WIDTH-1:0] mem_sysreg_q [DEPTH];
  logic [DATA_WIDTH-1:0]      mem_data_q   [DEPTH];

  // Control state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  state_t           state_q, state_d;

  // Registered outputs
  logic                       gpr_we_q, gpr_we_d;
  logic [REG_ID_WIDTH-1:0]    gpr_waddr_q, gpr_waddr_d;
  logic [DATA_WIDTH-1:0]      gpr_wdata_q, gpr_wdata_d;
  logic                       sys_req_q, sys_req_d;
  logic [SYSREG_ID_WIDTH-1:0] sys_id_q, sys_id_d;
  logic [DATA_WIDTH-1:0]      sys_data_q, sys_data_d;
  logic                       retire_valid_q, retire_valid_d;
  logic [ADDR_WIDTH-1:0]      retire_addr_q, retire_addr_d;

  logic push;
  logic pop;

  // Head-of-buffer view
  logic [ADDR_WIDTH-1:0]      hd_addr;
  logic                       hd_wen;
  logic                       hd_is_sys;
  logic [REG_ID_WIDTH-1:0]    hd_rd;
  logic [SYSREG_ID_WIDTH-1:0] hd_sysreg;
  logic [DATA_WIDTH-1:0]      hd_data;

  assign hd_addr   = mem_addr_q[rd_ptr_q];
  assign hd_wen    = mem_wen_q[rd_ptr_q];
  assign hd_is_sys = mem_is_sys_q[rd_ptr_q];
  assign hd_rd     = mem_rd_q[rd_ptr_q];
  assign hd_sysreg = mem_sysreg_q[rd_ptr_q];
  assign hd_data   = mem_data_q[rd_ptr_q];

  // in_ready is registered from the next occupancy. It therefore mirrors
  // "not full" every cycle, yet reads 0 during reset and only rises on the
  // first edge after reset is released.
  assign push = in_valid && in_ready_q;

  // Commit FSM: next state and next registered outputs
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    gpr_we_d       = 1'b0;
    gpr_waddr_d    = gpr_waddr_q;
    gpr_wdata_d    = gpr_wdata_q;
    sys_req_d      = sys_req_q;
    sys_id_d       = sys_id_q;
    sys_data_d     = sys_data_q;
    retire_valid_d = 1'b0;
    retire_addr_d  = retire_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          if (hd_wen && hd_is_sys) begin
            // The MTS entry stays at the head until acknowledged, which
            // stalls every younger entry behind it.
            sys_req_d  = 1'b1;
            sys_id_d   = hd_sysreg;
            sys_data_d = hd_data;
            state_d    = ST_SYS_WAIT;
          end else begin
            pop            = 1'b1;
            retire_valid_d = 1'b1;
            retire_addr_d  = hd_addr;
            // r0 is hardwired to zero, so a write to it is suppressed.
            if (hd_wen && (hd_rd != '0)) begin
              gpr_we_d    = 1'b1;
              gpr_waddr_d = hd_rd;
              gpr_wdata_d = hd_data;
            end
          end
        end
      end
      ST_SYS_WAIT: begin
        if (sys_ack) begin
          sys_req_d      = 1'b0;
          pop            = 1'b1;
          retire_valid_d = 1'b1;
          retire_addr_d  = hd_addr;
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sys_req_d = 1'b0;
      end
    endcase
  end

  // Buffer pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the pointers wrap naturally.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != FULL_CNT);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      in_ready_q     <= 1'b0;
      state_q        <= ST_IDLE;
      gpr_we_q       <= 1'b0;
      gpr_waddr_q    <= '0;
      gpr_wdata_q    <= '0;
      sys_req_q      <= 1'b0;
      sys_id_q       <= '0;
      sys_data_q     <= '0;
      retire_valid_q <= 1'b0;
      retire_addr_q  <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      in_ready_q     <= in_ready_d;
      state_q        <= state_d;
      gpr_we_q       <= gpr_we_d;
      gpr_waddr_q    <= gpr_waddr_d;
      gpr_wdata_q    <= gpr_wdata_d;
      sys_req_q      <= sys_req_d;
      sys_id_q       <= sys_id_d;
      sys_data_q     <= sys_data_d;
      retire_valid_q <= retire_valid_d;
      retire_addr_q  <= retire_addr_d;
    end
  end

  // Buffer write
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q]   <= in_addr;
      mem_wen_q[wr_ptr_q]    <= in_wen;
      mem_is_sys_q[wr_ptr_q] <= in_is_sys;
      mem_rd_q[wr_ptr_q]     <= in_rd;
      mem_sysreg_q[wr_ptr_q] <= in_sysreg;
      mem_data_q[wr_ptr_q]   <= in_data;
    end
  end

  assign in_ready     = in_ready_q;
  assign gpr_we       = gpr_we_q;
  assign gpr_waddr    = gpr_waddr_q;
  assign gpr_wdata    = gpr_wdata_q;
  assign sys_req      = sys_req_q;
  assign sys_id       = sys_id_q;
  assign sys_data     = sys_data_q;
  assign retire_valid = retire_valid_q;
  assign retire_addr  = retire_addr_q;

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retire_count_q, retire_count_d;

  // Increments on the same edge that raises retire_valid.
  always_comb begin
    retire_count_d = retire_count_q;
    if (retire_valid_d) retire_count_d = retire_count_q + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_count_q <= '0;
    else     retire_count_q <= retire_count_d;
  end

  assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] in_addr;
  logic        in_wen;
  logic        in_is_sys;
  logic [4:0]  in_rd;
  logic [9:0]  in_sysreg;
  logic [31:0] in_data;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        sys_req;
  logic [9:0]  sys_id;
  logic [31:0] sys_data;
  logic        sys_ack;
  logic        retire_valid;
  logic [29:0] retire_addr;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retire_count;
`endif

  int checks = 0;
  int errors = 0;

  write_back_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_wen       (in_wen),
    .in_is_sys    (in_is_sys),
    .in_rd        (in_rd),
    .in_sysreg    (in_sysreg),
    .in_data      (in_data),
    .gpr_we       (gpr_we),
    .gpr_waddr    (gpr_waddr),
    .gpr_wdata    (gpr_wdata),
    .sys_req      (sys_req),
    .sys_id       (sys_id),
    .sys_data     (sys_data),
    .sys_ack      (sys_ack),
    .retire_valid (retire_valid),
    .retire_addr  (retire_addr)
`ifdef WB_RETIRE_COUNT_EN
    ,
    .retire_count (retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Retire log captured away from the active edge
  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          cyc;
  } ret_t;

  ret_t ret_q[$];
  int   cyc        = 0;
  int   gpr_we_cnt = 0;
  int   both_hi    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (retire_valid === 1'b1)
      ret_q.push_back('{addr: retire_addr, we: gpr_we, waddr: gpr_waddr,
                        wdata: gpr_wdata, cyc: cyc});
    if (gpr_we === 1'b1) gpr_we_cnt++;
    if (gpr_we === 1'b1 && sys_req === 1'b1) both_hi++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [29:0] a, input logic w,
                        input logic s, input logic [4:0] rd,
                        input logic [9:0] sr, input logic [31:0] d);
    in_valid  = v;
    in_addr   = a;
    in_wen    = w;
    in_is_sys = s;
    in_rd     = rd;
    in_sysreg = sr;
    in_data   = d;
  endtask

  initial begin
    int base_we;
    rst     = 1'b1;
    sys_ack = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

    // ---- Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_gpr_we", gpr_we, 0);
    chk("rst_sys_req", sys_req, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_gpr_waddr", gpr_waddr, 0);
    chk("rst_gpr_wdata", gpr_wdata, 0);
    chk("rst_sys_id", sys_id, 0);
    chk("rst_sys_data", sys_data, 0);
    chk("rst_retire_addr", retire_addr, 0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", in_ready, 1);

    // ---- Single GPR result: two-cycle latency
    set_in(1'b1, 30'h100, 1'b1, 1'b0, 5'd3, '0, 32'hDEADBEEF);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("t1_no_early_retire", retire_valid, 0);
    tick();
    chk("t1_gpr_we", gpr_we, 1);
    chk("t1_gpr_waddr", gpr_waddr, 3);
    chk("t1_gpr_wdata", gpr_wdata, 32'hDEADBEEF);
    chk("t1_retire_valid", retire_valid, 1);
    chk("t1_retire_addr", retire_addr, 30'h100);
    tick();
    chk("t1_gpr_we_drops", gpr_we, 0);
    chk("t1_retire_drops", retire_valid, 0);
    ret_q.delete();

    // ---- r0 write and no-write: retire only
    base_we = gpr_we_cnt;
    set_in(1'b1, 30'h200, 1'b1, 1'b0, 5'd0, '0, 32'h12345678);
    tick();
    set_in(1'b1, 30'h201, 1'b0, 1'b0, 5'd7, '0, 32'h87654321);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick(); tick(); tick();
    chk("t2_retire_count", ret_q.size(), 2);
    if (ret_q.size() == 2) begin
      chk("t2_addr0", ret_q[0].addr, 30'h200);
      chk("t2_addr1", ret_q[1].addr, 30'h201);
      chk("t2_consecutive", ret_q[1].cyc - ret_q[0].cyc, 1);
    end
    chk("t2_no_gpr_we", gpr_we_cnt - base_we, 0);
    ret_q.delete();

    // ---- MTS blocks younger GPR results until acknowledged
    set_in(1'b1, 30'h300, 1'b1, 1'b1, 5'd9, 10'h2A, 32'h5);
    tick();
    set_in(1'b1, 30'h301, 1'b1, 1'b0, 5'd4, '0, 32'h11);
    tick();
    set_in(1'b1, 30'h302, 1'b1, 1'b0, 5'd5, '0, 32'h22);
    chk("t3_sys_req", sys_req, 1);
    chk("t3_sys_id", sys_id, 10'h2A);
    chk("t3_sys_data", sys_data, 32'h5);
    chk("t3_in_ready_full", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_sys_req_held", sys_req, 1);
      chk("t3_sys_id_held", sys_id, 10'h2A);
      chk("t3_full_held", in_ready, 0);
      chk("t3_no_retire_wait", retire_valid, 0);
    end
    sys_ack = 1'b1;
    tick();
    sys_ack = 1'b0;
    chk("t3_sys_req_drop", sys_req, 0);
    chk("t3_sys_retire", retire_valid, 1);
    chk("t3_sys_retire_addr", retire_addr, 30'h300);
    chk("t3_ready_again", in_ready, 1);
    tick();
    set_in(1'b1, 30'h303, 1'b1, 1'b0, 5'd6, '0, 32'h33);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick(); tick(); tick();
    chk("t3_retire_count", ret_q.size(), 4);
    if (ret_q.size() == 4) begin
      chk("t3_r0_addr", ret_q[0].addr, 30'h300);
      chk("t3_r0_we", ret_q[0].we, 0);
      for (int i = 1; i < 4; i++) begin
        chk("t3_ri_addr", ret_q[i].addr, 30'h300 + 30'(i));
        chk("t3_ri_we", ret_q[i].we, 1);
        chk("t3_ri_waddr", ret_q[i].waddr, 5'd3 + 5'(i));
        chk("t3_ri_wdata", ret_q[i].wdata, 32'h11 * 32'(i));
      end
    end
    ret_q.delete();

    // ---- Eight back-to-back GPR results
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 30'h400 + 30'(i), 1'b1, 1'b0, 5'(i + 1), '0, 32'hA0 + 32'(i));
      chk("t4_in_ready", in_ready, 1);
      tick();
    end
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick(); tick(); tick();
    chk("t4_retire_count", ret_q.size(), 8);
    if (ret_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t4_addr", ret_q[i].addr, 30'h400 + 30'(i));
        chk("t4_we", ret_q[i].we, 1);
        chk("t4_waddr", ret_q[i].waddr, 5'(i + 1));
        chk("t4_wdata", ret_q[i].wdata, 32'hA0 + 32'(i));
        if (i > 0) chk("t4_consecutive", ret_q[i].cyc - ret_q[i-1].cyc, 1);
      end
    end
    ret_q.delete();

    // ---- Reset during SYS_WAIT with two buffered entries
    set_in(1'b1, 30'h500, 1'b1, 1'b1, '0, 10'h3C, 32'h77);
    tick();
    set_in(1'b1, 30'h501, 1'b1, 1'b0, 5'd8, '0, 32'h88);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("t5_sys_req_before", sys_req, 1);
    chk("t5_full_before", in_ready, 0);
    ret_q.delete();
    base_we = gpr_we_cnt;
    rst = 1'b1;
    #1;
    chk("t5_sys_req_async", sys_req, 0);
    chk("t5_in_ready_rst", in_ready, 0);
    tick();
    chk("t5_sys_req_rst", sys_req, 0);
    chk("t5_in_ready_rst2", in_ready, 0);
    rst = 1'b0;
    chk("t5_in_ready_at_release", in_ready, 0);
    tick();
    chk("t5_in_ready_after", in_ready, 1);
    sys_ack = 1'b1;
    tick();
    sys_ack = 1'b0;
    tick(); tick(); tick();
    chk("t5_no_retire", ret_q.size(), 0);
    chk("t5_no_sys_req", sys_req, 0);
    chk("t5_no_gpr_we", gpr_we_cnt - base_we, 0);

`ifdef WB_RETIRE_COUNT_EN
    // ---- Retire counter: five retires, then wrap from all-ones
    chk("t6_count_reset", retire_count, 0);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 30'h600 + 30'(i), 1'b0, 1'b0, '0, '0, '0);
      tick();
    end
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick(); tick();
    chk("t6_count_five", retire_count, 64'd5);
    force dut.retire_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_count_q;
    chk("t6_count_preload", retire_count, 64'hFFFF_FFFF_FFFF_FFFF);
    set_in(1'b1, 30'h610, 1'b0, 1'b0, '0, '0, '0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("t6_wrap_retire", retire_valid, 1);
    chk("t6_count_wrap", retire_count, 64'd0);
`endif

    chk("never_gpr_and_sys", both_hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
